// File: rtl/pwm_multi_core.sv
// pwm_multi_core: multi-channel PWM timer core with edge- or center-aligned counting.
// The counter advances on a prescaler clock-enable. Configuration is held in shadow
// registers that reload only at a period boundary or while the core is disabled.
// Ports:
//   clk_i, rst_i         core clock, asynchronous active-high reset
//   en_i, clr_i          run enable, synchronous clear of prescaler/counter/direction
//   ovie_i, irq_clr_i    overflow interrupt enable, sticky irq clear pulse
//   upd_req_i/upd_ack_o  shadow-load handshake (request held until ack)
//   mode_i, pscr_i, cmp_i, crx_i, pol_i   configuration inputs, shadowed
//   pwm_o, cnt_o, ov_o, irq_o             registered outputs
module pwm_multi_core #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PSCR_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        clr_i,
  input  logic                        ovie_i,
  input  logic                        irq_clr_i,
  input  logic                        upd_req_i,
  output logic                        upd_ack_o,
  input  logic                        mode_i,
  input  logic [PSCR_WIDTH-1:0]       pscr_i,
  input  logic [CNT_WIDTH-1:0]        cmp_i,
  input  logic [CH_NUM*CNT_WIDTH-1:0] crx_i,
  input  logic [CH_NUM-1:0]           pol_i,
  output logic [CH_NUM-1:0]           pwm_o,
  output logic [CNT_WIDTH-1:0]        cnt_o,
  output logic                        ov_o,
  output logic                        irq_o
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [PSCR_WIDTH-1:0]              pscr_q, pre_q, pre_top;
  logic [CNT_WIDTH-1:0]               cmp_q, cnt_q, cmp_m1, cnt_nxt;
  logic [CH_NUM-1:0][CNT_WIDTH-1:0]   cr_q;
  logic [CH_NUM-1:0]                  pol_q, pwm_q, pwm_nxt;
  logic                               mode_q, ov_q, irq_q, ack_q;
  dir_t                               dir_q, dir_nxt;
  logic                               pre_last, tick, wrap, period_evt, load;

  always_comb begin
    // pscr of 0 behaves as a divide-by-1
    pre_top    = (pscr_q == '0) ? '0 : pscr_q - PSCR_WIDTH'(1);
    pre_last   = (pre_q == pre_top);
    tick       = en_i & ~clr_i & pre_last;
    cmp_m1     = cmp_q - CNT_WIDTH'(1);
    cnt_nxt    = cnt_q;
    dir_nxt    = dir_q;
    wrap       = 1'b0;
    if (cmp_q < CNT_WIDTH'(2)) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
      wrap    = 1'b1;
    end else if (!mode_q) begin
      dir_nxt = DIR_UP;
      if (cnt_q == cmp_m1) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt_q + CNT_WIDTH'(1);
      end
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= cmp_m1) begin
        // cmp_q==2 has no interior down step: the top of the ramp is also the period end
        if (cmp_m1 == CNT_WIDTH'(1)) begin
          cnt_nxt = '0;
          wrap    = 1'b1;
        end else begin
          cnt_nxt = cmp_q - CNT_WIDTH'(2);
          dir_nxt = DIR_DOWN;
        end
      end else begin
        cnt_nxt = cnt_q + CNT_WIDTH'(1);
      end
    end else begin
      if (cnt_q <= CNT_WIDTH'(1)) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt_q - CNT_WIDTH'(1);
      end
    end
    period_evt = tick & wrap;
    // ack_q masks the still-held request in the ack cycle so one request loads once
    load       = upd_req_i & ~ack_q & (period_evt | ~en_i);
    pwm_nxt    = pol_q;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (en_i) pwm_nxt[k] = (cnt_q >= cr_q[k]) ^ pol_q[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      pscr_q <= '0;
      cmp_q  <= '0;
      cr_q   <= '0;
      pol_q  <= '0;
      mode_q <= 1'b0;
      pwm_q  <= '0;
      ov_q   <= 1'b0;
      irq_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      if (clr_i || (load && !en_i)) begin
        pre_q <= '0;
        cnt_q <= '0;
        dir_q <= DIR_UP;
      end else if (en_i) begin
        pre_q <= pre_last ? '0 : pre_q + PSCR_WIDTH'(1);
        if (tick) begin
          cnt_q <= cnt_nxt;
          dir_q <= dir_nxt;
        end
      end
      if (load) begin
        pscr_q <= pscr_i;
        cmp_q  <= cmp_i;
        cr_q   <= crx_i;
        pol_q  <= pol_i;
        mode_q <= mode_i;
      end
      ack_q <= load;
      ov_q  <= period_evt;
      pwm_q <= pwm_nxt;
      if (ovie_i && period_evt) irq_q <= 1'b1;
      else if (irq_clr_i)       irq_q <= 1'b0;
    end
  end

  assign upd_ack_o = ack_q;
  assign pwm_o     = pwm_q;
  assign cnt_o     = cnt_q;
  assign ov_o      = ov_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_pwm_multi_core.sv
// tb_pwm_multi_core: directed stimulus for pwm_multi_core with a phase-based reference
// model compared every cycle, plus literal expectations for the documented scenarios.
module tb_pwm_multi_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, clr = 1'b0, ovie = 1'b0, irq_clr = 1'b0, upd_req = 1'b0, mode = 1'b0;
  logic [15:0] pscr = '0, cmp = '0;
  logic [63:0] crx = '0;
  logic [3:0]  pol = '0;
  logic        upd_ack, ov, irq;
  logic [3:0]  pwm;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pwm_multi_core #(.CH_NUM(4), .CNT_WIDTH(16), .PSCR_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .ovie_i(ovie), .irq_clr_i(irq_clr),
    .upd_req_i(upd_req), .upd_ack_o(upd_ack), .mode_i(mode), .pscr_i(pscr), .cmp_i(cmp),
    .crx_i(crx), .pol_i(pol), .pwm_o(pwm), .cnt_o(cnt), .ov_o(ov), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the period as a phase index; the counter value
  // follows from the phase (a ramp for edge mode, a triangle for center mode).
  int       m_pre, m_phase, m_pscr, m_cmp, m_cnt;
  int       m_cr[4];
  bit [3:0] m_pol, m_pwm;
  bit       m_mode, m_ov, m_irq, m_ack;
  int       t_p, t_len, t_c;
  bit       t_tick, t_pe, t_ld;

  function automatic int cnt_of(int ph, int c, bit md);
    if (c < 2) return 0;
    if (!md) return ph;
    return (ph <= c - 1) ? ph : 2 * (c - 1) - ph;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre = 0; m_phase = 0; m_pscr = 0; m_cmp = 0; m_cnt = 0;
      for (int k = 0; k < 4; k++) m_cr[k] = 0;
      m_pol = '0; m_pwm = '0; m_mode = 0; m_ov = 0; m_irq = 0; m_ack = 0;
    end else begin
      t_p    = (m_pscr == 0) ? 1 : m_pscr;
      t_len  = (m_cmp < 2) ? 1 : (m_mode ? 2 * (m_cmp - 1) : m_cmp);
      t_c    = cnt_of(m_phase, m_cmp, m_mode);
      t_tick = en && !clr && (m_pre == t_p - 1);
      t_pe   = t_tick && (m_phase == t_len - 1);
      t_ld   = upd_req && !m_ack && (t_pe || !en);
      for (int k = 0; k < 4; k++) m_pwm[k] = en ? ((t_c >= m_cr[k]) ^ m_pol[k]) : m_pol[k];
      if (clr) begin
        m_pre = 0; m_phase = 0;
      end else if (en) begin
        m_pre = t_tick ? 0 : m_pre + 1;
        if (t_tick) m_phase = (m_phase + 1) % t_len;
      end
      if (t_ld && !en) begin
        m_pre = 0; m_phase = 0;
      end
      if (t_ld) begin
        m_pscr = pscr; m_cmp = cmp; m_mode = mode; m_pol = pol;
        for (int k = 0; k < 4; k++) m_cr[k] = crx[k*16 +: 16];
      end
      m_ack = t_ld;
      m_ov  = t_pe;
      if (ovie && t_pe) m_irq = 1;
      else if (irq_clr) m_irq = 0;
      m_cnt = cnt_of(m_phase, m_cmp, m_mode);
    end
  end

  always @(negedge clk) begin
    chk("pwm_o", pwm, m_pwm);
    chk("cnt_o", cnt, m_cnt);
    chk("ov_o", ov, m_ov);
    chk("irq_o", irq, m_irq);
    chk("upd_ack_o", upd_ack, m_ack);
  end

  // which: 0 = ov_o, 1 = upd_ack_o; returns the cycle index of the first hit
  task automatic wait_for(input string name, input int which, output int at);
    bit found = 0;
    at = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if ((which == 0 && ov === 1'b1) || (which == 1 && upd_ack === 1'b1)) begin
        found = 1;
        at = cyc;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected pulse within 100 cycles", name);
    end
  endtask

  int a, b, hi, acks, mx;
  int cseq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

  initial begin
    @(negedge clk);
    chk("rst_cnt", cnt, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_ack", upd_ack, 0);
    @(posedge clk); #1 rst = 0;

    // Edge mode: load while disabled
    pscr = 2; cmp = 10; crx = {16'd0, 16'd8, 16'd5, 16'd2}; pol = '0; mode = 0; upd_req = 1;
    @(posedge clk); @(negedge clk);
    chk("edge_ack", upd_ack, 1);
    @(posedge clk); #1 upd_req = 0; en = 1;
    wait_for("edge_ov", 0, a);
    hi = 0;
    repeat (20) begin hi += int'(pwm[1]); @(negedge clk); end
    chk("edge_pwm1_high", hi, 10);
    chk("edge_ov_every_20", ov, 1);

    // Shadow reload mid-period
    repeat (5) @(posedge clk);
    #1 cmp = 4; upd_req = 1;
    wait_for("shadow_ack", 1, a);
    chk("shadow_ack_cnt", cnt, 0);
    chk("shadow_ack_ov", ov, 1);
    @(posedge clk); #1 upd_req = 0;
    acks = 0; mx = 0;
    repeat (16) begin
      @(negedge clk);
      acks += int'(upd_ack);
      if (int'(cnt) > mx) mx = int'(cnt);
    end
    chk("shadow_single_ack", acks, 0);
    chk("shadow_max_cnt", mx, 3);
    wait_for("shadow_ov_a", 0, a);
    wait_for("shadow_ov_b", 0, b);
    chk("shadow_period", b - a, 8);

    // Center mode, pscr 0 behaves as 1
    mode = 1; cmp = 5; pscr = 0; upd_req = 1;
    wait_for("center_ack", 1, a);
    @(posedge clk); #1 upd_req = 0;
    wait_for("center_ov", 0, a);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      chk("center_cnt_seq", cnt, cseq[i]);
      hi += int'(pwm[0]);
      @(negedge clk);
    end
    chk("center_ov_every_8", ov, 1);
    chk("center_pwm0_high", hi, 5);

    // IRQ set, clear, and set-wins-over-clear
    ovie = 1;
    wait_for("irq_ov", 0, a);
    chk("irq_set", irq, 1);
    @(posedge clk); #1 irq_clr = 1;
    @(posedge clk); #1 irq_clr = 0;
    @(negedge clk);
    chk("irq_cleared", irq, 0);
    repeat (5) @(posedge clk);
    #1 irq_clr = 1;
    @(posedge clk); #1 irq_clr = 0;
    @(negedge clk);
    chk("irq_set_wins_ov", ov, 1);
    chk("irq_set_wins", irq, 1);

    // clr on the wrap cycle suppresses the period event
    repeat (7) @(posedge clk);
    #1 clr = 1;
    @(posedge clk); #1 clr = 0;
    @(negedge clk);
    chk("clr_no_ov", ov, 0);
    chk("clr_cnt", cnt, 0);

    // Polarity and idle level
    @(posedge clk); #1 en = 0; pol = 4'b0101; crx = '0; mode = 0; cmp = 10; pscr = 0; upd_req = 1;
    @(posedge clk); #1 upd_req = 0;
    @(posedge clk); @(negedge clk);
    chk("pol_idle", pwm, 4'b0101);
    en = 1;
    @(posedge clk); @(negedge clk);
    chk("pol_active", pwm, 4'b1010);

    // Asynchronous reset mid-count
    wait_for("rst_ov", 0, a);
    repeat (7) @(posedge clk);
    #2 chk("pre_rst_cnt", cnt, 7);
    rst = 1;
    #1;
    chk("async_rst_pwm", pwm, 0);
    chk("async_rst_cnt", cnt, 0);
    chk("async_rst_ov", ov, 0);
    chk("async_rst_irq", irq, 0);
    chk("async_rst_ack", upd_ack, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_cnt", cnt, 0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
